// File: rtl/float_norm_pkg.sv
// float_norm_pkg
// Shared definitions for the float result normalizer slice.
//   - default mantissa/exponent widths and the widths derived from them
//   - the normalizer FSM state encoding
//   - saturation constants used when the exponent overflows
package float_norm_pkg;

    // Output format: MANT_W bits including the explicit leading 1, EXP_W bits of exponent.
    localparam int DEF_MANT_W    = 11;
    localparam int DEF_EXP_W     = 5;

    // Raw adder result carries one extra mantissa bit (carry) and one extra exponent bit.
    localparam int DEF_IN_MANT_W = DEF_MANT_W + 1;
    localparam int DEF_IN_EXP_W  = DEF_EXP_W + 1;

    // Working exponent is two bits wider than the output so that an increment
    // from the largest input exponent can never wrap.
    localparam int DEF_INT_EXP_W = DEF_EXP_W + 2;

    // Saturated result for exponent overflow (default widths).
    localparam logic [DEF_MANT_W-1:0] SAT_MANT = '1;
    localparam logic [DEF_EXP_W-1:0]  SAT_EXP  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : float_norm_pkg

// File: rtl/float_result_normalizer_step.sv
// norm_shift_step
// One combinational normalization step. Given the working mantissa and
// exponent it either produces the shifted mantissa/exponent for the next
// iteration, or declares the result finished together with the final
// output fields and the zero / overflow / underflow decision.
//
// Ports:
//   mant        in   MANT_W+1  working mantissa (bit MANT_W = carry)
//   exp         in   EXP_W+2   working exponent (unsigned, never wraps)
//   next_mant   out  MANT_W+1  mantissa for the next iteration
//   next_exp    out  EXP_W+2   exponent for the next iteration
//   done        out  1         result is final this step
//   zero        out  1         final result is zero
//   ovf         out  1         exponent overflow, result saturated
//   unf         out  1         exponent underflow, result flushed to zero
//   clear_sgn   out  1         final sign must be forced to 0
//   res_mant    out  MANT_W    final mantissa (valid when done)
//   res_exp     out  EXP_W     final exponent (valid when done)
module norm_shift_step
    import float_norm_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic [MANT_W:0]  mant,
    input  logic [EXP_W+1:0] exp,
    output logic [MANT_W:0]  next_mant,
    output logic [EXP_W+1:0] next_exp,
    output logic             done,
    output logic             zero,
    output logic             ovf,
    output logic             unf,
    output logic             clear_sgn,
    output logic [MANT_W-1:0] res_mant,
    output logic [EXP_W-1:0]  res_exp
);

    // Largest exponent representable in the output format.
    localparam logic [EXP_W+1:0] MAX_EXP = {2'b00, {EXP_W{1'b1}}};

    always_comb begin
        next_mant = mant;
        next_exp  = exp;
        done      = 1'b0;
        zero      = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        clear_sgn = 1'b0;
        res_mant  = '0;
        res_exp   = '0;

        if (mant == '0) begin
            // True zero: canonical +0 regardless of the incoming sign.
            done      = 1'b1;
            zero      = 1'b1;
            clear_sgn = 1'b1;
        end else if (mant[MANT_W]) begin
            // Carry out of the adder: shift right, dropping the LSB
            // (round toward zero).
            next_mant = mant >> 1;
            next_exp  = exp + 1'b1;
        end else if (mant[MANT_W-1]) begin
            done = 1'b1;
            if (exp > MAX_EXP) begin
                ovf      = 1'b1;
                res_mant = {MANT_W{1'b1}};
                res_exp  = {EXP_W{1'b1}};
            end else begin
                res_mant = mant[MANT_W-1:0];
                res_exp  = exp[EXP_W-1:0];
            end
        end else if (exp == '0) begin
            // Would need a left shift below exponent 0: flush to zero.
            done      = 1'b1;
            unf       = 1'b1;
            clear_sgn = 1'b1;
        end else begin
            next_mant = mant << 1;
            next_exp  = exp - 1'b1;
        end
    end

endmodule : norm_shift_step

// File: rtl/float_result_normalizer.sv
// float_result_normalizer
// Brings the raw add/subtract result (12-bit unnormalized mantissa with
// carry, 6-bit exponent) back to operand format (11-bit mantissa with the
// leading 1 explicit, 5-bit exponent). One shift per clock under an
// IDLE -> NORM -> DONE state machine.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both high. The producer holds valid and data until that
// edge; ready may depend on state but never on the partner's valid.
// The output side holds out_valid and all out_* fields stable until
// out_ready is sampled high. in_ready is high only in IDLE and never while
// rst is asserted; a result cannot be consumed and a new input accepted
// in the same cycle.
//
// Ports:
//   clk          in   1         clock, rising edge
//   rst          in   1         synchronous active-high reset
//   in_valid     in   1         input result present
//   in_ready     out  1         block can accept an input
//   in_sgn       in   1         result sign
//   in_mant      in   MANT_W+1  unnormalized mantissa (bit MANT_W = carry)
//   in_exp       in   EXP_W+1   unsigned exponent
//   out_valid    out  1         normalized result held
//   out_ready    in   1         consumer accepts the result
//   out_sgn      out  1         sign
//   out_mant     out  MANT_W    normalized mantissa
//   out_exp      out  EXP_W     exponent
//   out_zero     out  1         result is zero
//   out_ovf      out  1         exponent overflow, result saturated
//   out_unf      out  1         exponent underflow, result flushed to zero
//   debug_state  out  state_t   current FSM state
module float_result_normalizer
    import float_norm_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sgn,
    input  logic [MANT_W:0]   in_mant,
    input  logic [EXP_W:0]    in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sgn,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf,
    output state_t            debug_state
);

    state_t              state;
    logic                sgn_r;
    logic [MANT_W:0]     mant_r;
    logic [EXP_W+1:0]    exp_r;

    logic [MANT_W:0]     step_next_mant;
    logic [EXP_W+1:0]    step_next_exp;
    logic                step_done;
    logic                step_zero;
    logic                step_ovf;
    logic                step_unf;
    logic                step_clear_sgn;
    logic [MANT_W-1:0]   step_res_mant;
    logic [EXP_W-1:0]    step_res_exp;

    norm_shift_step #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_step (
        .mant      (mant_r),
        .exp       (exp_r),
        .next_mant (step_next_mant),
        .next_exp  (step_next_exp),
        .done      (step_done),
        .zero      (step_zero),
        .ovf       (step_ovf),
        .unf       (step_unf),
        .clear_sgn (step_clear_sgn),
        .res_mant  (step_res_mant),
        .res_exp   (step_res_exp)
    );

    // Gated by rst so the producer never sees a transfer that reset will discard.
    assign in_ready    = (state == IDLE) && !rst;
    assign debug_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sgn_r     <= 1'b0;
            mant_r    <= '0;
            exp_r     <= '0;
            out_valid <= 1'b0;
            out_sgn   <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sgn_r  <= in_sgn;
                        mant_r <= in_mant;
                        exp_r  <= {1'b0, in_exp};
                        state  <= NORM;
                    end
                end

                NORM: begin
                    if (step_done) begin
                        out_valid <= 1'b1;
                        out_sgn   <= step_clear_sgn ? 1'b0 : sgn_r;
                        out_mant  <= step_res_mant;
                        out_exp   <= step_res_exp;
                        out_zero  <= step_zero;
                        out_ovf   <= step_ovf;
                        out_unf   <= step_unf;
                        state     <= DONE;
                    end else begin
                        mant_r <= step_next_mant;
                        exp_r  <= step_next_exp;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        // Data fields are left as-is; they are don't-care
                        // once out_valid drops. Flags are cleared.
                        out_valid <= 1'b0;
                        out_zero  <= 1'b0;
                        out_ovf   <= 1'b0;
                        out_unf   <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : float_result_normalizer
